// File: rtl/knn_pkg.sv
// Shared definitions for the k-nearest-neighbour classifier: FSM states, distance width, empty-entry values.
// The VOTE state exists only when KNN_CTRL_VOTE_EN is defined.
package knn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DIST   = 3'd2,
        ST_INSERT = 3'd3,
`ifdef KNN_CTRL_VOTE_EN
        ST_VOTE   = 3'd4,
`endif
        ST_DONE   = 3'd5
    } knn_state_e;

    localparam int unsigned KNN_MAX_DIST_W = 64;

    // An empty list slot sits behind every real distance and never takes part in a vote.
    localparam logic [KNN_MAX_DIST_W-1:0] KNN_EMPTY_DIST  = {KNN_MAX_DIST_W{1'b1}};
    localparam logic                      KNN_EMPTY_VALID = 1'b0;

    function automatic int unsigned knn_dist_w(input int unsigned coord_w);
        return 2 * coord_w + 2;
    endfunction

endpackage

// File: rtl/knn_dist.sv
// Combinational squared Euclidean distance between two signed points.
// The output is two bits wider than the product, so no input pair can overflow it.
module knn_dist #(
    parameter int COORD_W = 16
) (
    input  logic signed [COORD_W-1:0]   i_ax,
    input  logic signed [COORD_W-1:0]   i_ay,
    input  logic signed [COORD_W-1:0]   i_bx,
    input  logic signed [COORD_W-1:0]   i_by,
    output logic        [2*COORD_W+1:0] o_dist
);

    logic signed [COORD_W:0]     w_dx;
    logic signed [COORD_W:0]     w_dy;
    logic signed [2*COORD_W+1:0] w_dx_e;
    logic signed [2*COORD_W+1:0] w_dy_e;
    logic signed [2*COORD_W+1:0] w_sum;

    // Differences are formed one bit wider so -32768 - 32767 cannot wrap.
    assign w_dx   = {i_ax[COORD_W-1], i_ax} - {i_bx[COORD_W-1], i_bx};
    assign w_dy   = {i_ay[COORD_W-1], i_ay} - {i_by[COORD_W-1], i_by};
    assign w_dx_e = {{(COORD_W+1){w_dx[COORD_W]}}, w_dx};
    assign w_dy_e = {{(COORD_W+1){w_dy[COORD_W]}}, w_dy};
    assign w_sum  = (w_dx_e * w_dx_e) + (w_dy_e * w_dy_e);
    assign o_dist = $unsigned(w_sum);

endmodule

// File: rtl/knn_ctrl.sv
// k-nearest-neighbour controller: fetches training points, keeps the K nearest in a sorted list.
// Define KNN_CTRL_VOTE_EN for a majority vote over the list; otherwise the nearest label wins.
module knn_ctrl
    import knn_pkg::*;
#(
    parameter int COORD_W = 16,
    parameter int LABEL_W = 8,
    parameter int K       = 4,
    parameter int NPTS_W  = 8,
    localparam int IDX_W  = (K > 1) ? $clog2(K) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [NPTS_W-1:0]      npts,
    input  logic [COORD_W-1:0]     tx,
    input  logic [COORD_W-1:0]     ty,
    output logic                   pt_req,
    output logic [NPTS_W-1:0]      pt_addr,
    input  logic                   pt_valid,
    input  logic [COORD_W-1:0]     pt_x,
    input  logic [COORD_W-1:0]     pt_y,
    input  logic [LABEL_W-1:0]     pt_label,
    output logic                   busy,
    output logic                   done,
    output logic [LABEL_W-1:0]     best_label,
    output logic [2*COORD_W+1:0]   best_dist,
    input  logic [IDX_W-1:0]       nb_idx,
    output logic [2*COORD_W+1:0]   nb_dist,
    output logic [LABEL_W-1:0]     nb_label
);

    localparam int unsigned          DIST_W     = knn_dist_w(COORD_W);
    localparam logic [DIST_W-1:0]    EMPTY_DIST = KNN_EMPTY_DIST[DIST_W-1:0];

    knn_state_e                      r_state;
    logic signed [COORD_W-1:0]       r_tx;
    logic signed [COORD_W-1:0]       r_ty;
    logic signed [COORD_W-1:0]       r_px;
    logic signed [COORD_W-1:0]       r_py;
    logic [LABEL_W-1:0]              r_plabel;
    logic [NPTS_W-1:0]               r_npts;
    logic [NPTS_W-1:0]               r_idx;
    logic [DIST_W-1:0]               r_d;
    logic [K-1:0][DIST_W-1:0]        r_dist;
    logic [K-1:0][LABEL_W-1:0]       r_label;
    logic [K-1:0]                    r_valid;
    logic                            r_pt_req;
    logic [NPTS_W-1:0]               r_pt_addr;
    logic                            r_busy;
    logic                            r_done;
    logic [LABEL_W-1:0]              r_best_label;
    logic [DIST_W-1:0]               r_best_dist;

    logic [DIST_W-1:0]               w_dist;
    logic [K-1:0]                    w_le;
    logic [K-1:0][DIST_W-1:0]        w_nxt_dist;
    logic [K-1:0][LABEL_W-1:0]       w_nxt_label;
    logic [K-1:0]                    w_nxt_valid;

    knn_dist #(
        .COORD_W (COORD_W)
    ) u_dist (
        .i_ax   (r_px),
        .i_ay   (r_py),
        .i_bx   (r_tx),
        .i_by   (r_ty),
        .o_dist (w_dist)
    );

    // Sorted insert: entries at or below the new distance stay, the rest slide down one slot.
    always_comb begin
        w_le        = '0;
        w_nxt_dist  = r_dist;
        w_nxt_label = r_label;
        w_nxt_valid = r_valid;
        for (int i = 0; i < K; i++) begin
            w_le[i] = r_valid[i] && (r_dist[i] <= r_d);
        end
        if (!w_le[0]) begin
            w_nxt_dist[0]  = r_d;
            w_nxt_label[0] = r_plabel;
            w_nxt_valid[0] = 1'b1;
        end else begin
            w_nxt_dist[0]  = r_dist[0];
        end
        for (int i = 1; i < K; i++) begin
            if (w_le[i]) begin
                w_nxt_dist[i]  = r_dist[i];
            end else if (w_le[i-1]) begin
                w_nxt_dist[i]  = r_d;
                w_nxt_label[i] = r_plabel;
                w_nxt_valid[i] = 1'b1;
            end else begin
                w_nxt_dist[i]  = r_dist[i-1];
                w_nxt_label[i] = r_label[i-1];
                w_nxt_valid[i] = r_valid[i-1];
            end
        end
    end

`ifdef KNN_CTRL_VOTE_EN
    localparam int                   CNT_W    = $clog2(K + 1);
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(K - 1);

    logic [IDX_W-1:0]                r_vidx;
    logic [CNT_W-1:0]                r_vbest_cnt;
    logic [LABEL_W-1:0]              r_vbest_label;
    logic [CNT_W-1:0]                w_vcnt;
    logic [LABEL_W-1:0]              w_vsel_label;

    // Occurrences of the currently examined entry's label among valid entries.
    always_comb begin
        w_vcnt       = '0;
        w_vsel_label = r_label[r_vidx];
        for (int j = 0; j < K; j++) begin
            if (r_valid[j] && (r_label[j] == w_vsel_label)) begin
                w_vcnt = w_vcnt + CNT_W'(1);
            end else begin
                w_vcnt = w_vcnt;
            end
        end
    end
`endif

    // Main sequencer: start latch, point fetch, distance, insert, optional vote, result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_tx         <= '0;
            r_ty         <= '0;
            r_px         <= '0;
            r_py         <= '0;
            r_plabel     <= '0;
            r_npts       <= '0;
            r_idx        <= '0;
            r_d          <= '0;
            r_dist       <= {K{EMPTY_DIST}};
            r_label      <= '0;
            r_valid      <= {K{KNN_EMPTY_VALID}};
            r_pt_req     <= 1'b0;
            r_pt_addr    <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_best_label <= '0;
            r_best_dist  <= '0;
`ifdef KNN_CTRL_VOTE_EN
            r_vidx        <= '0;
            r_vbest_cnt   <= '0;
            r_vbest_label <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_tx      <= $signed(tx);
                        r_ty      <= $signed(ty);
                        r_npts    <= npts;
                        r_idx     <= '0;
                        r_dist    <= {K{EMPTY_DIST}};
                        r_label   <= '0;
                        r_valid   <= {K{KNN_EMPTY_VALID}};
                        r_busy    <= 1'b1;
                        r_pt_addr <= '0;
`ifdef KNN_CTRL_VOTE_EN
                        r_vidx        <= '0;
                        r_vbest_cnt   <= '0;
                        r_vbest_label <= '0;
`endif
                        if (npts != '0) begin
                            r_pt_req <= 1'b1;
                            r_state  <= ST_FETCH;
                        end else begin
                            r_state  <= ST_DONE;
                        end
                    end
                end
                ST_FETCH: begin
                    if (pt_valid) begin
                        r_px     <= $signed(pt_x);
                        r_py     <= $signed(pt_y);
                        r_plabel <= pt_label;
                        r_pt_req <= 1'b0;
                        r_state  <= ST_DIST;
                    end
                end
                ST_DIST: begin
                    r_d     <= w_dist;
                    r_state <= ST_INSERT;
                end
                ST_INSERT: begin
                    r_dist  <= w_nxt_dist;
                    r_label <= w_nxt_label;
                    r_valid <= w_nxt_valid;
                    if (r_idx == (r_npts - NPTS_W'(1))) begin
`ifdef KNN_CTRL_VOTE_EN
                        r_vidx  <= '0;
                        r_state <= ST_VOTE;
`else
                        r_state <= ST_DONE;
`endif
                    end else begin
                        r_idx     <= r_idx + NPTS_W'(1);
                        r_pt_addr <= r_idx + NPTS_W'(1);
                        r_pt_req  <= 1'b1;
                        r_state   <= ST_FETCH;
                    end
                end
`ifdef KNN_CTRL_VOTE_EN
                ST_VOTE: begin
                    // Strictly-greater keeps the nearest entry on a count tie.
                    if (r_valid[r_vidx] && (w_vcnt > r_vbest_cnt)) begin
                        r_vbest_cnt   <= w_vcnt;
                        r_vbest_label <= w_vsel_label;
                    end
                    if (r_vidx == LAST_IDX) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_vidx  <= r_vidx + IDX_W'(1);
                    end
                end
`endif
                ST_DONE: begin
                    r_done      <= 1'b1;
                    r_busy      <= 1'b0;
                    r_best_dist <= r_dist[0];
`ifdef KNN_CTRL_VOTE_EN
                    r_best_label <= r_vbest_label;
`else
                    r_best_label <= r_label[0];
`endif
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_busy   <= 1'b0;
                    r_pt_req <= 1'b0;
                end
            endcase
        end
    end

    // Combinational readback of the sorted neighbour list.
    always_comb begin
        nb_dist  = EMPTY_DIST;
        nb_label = '0;
        if (32'(nb_idx) < 32'(K)) begin
            nb_dist  = r_dist[nb_idx];
            nb_label = r_label[nb_idx];
        end else begin
            nb_dist  = EMPTY_DIST;
            nb_label = '0;
        end
    end

    assign pt_req     = r_pt_req;
    assign pt_addr    = r_pt_addr;
    assign busy       = r_busy;
    assign done       = r_done;
    assign best_label = r_best_label;
    assign best_dist  = r_best_dist;

endmodule

// File: doc/knn_ctrl.md
KNN_CTRL -- requirements
Module: knn_ctrl

Interface
REQ-001 SHALL have parameter COORD_W, default 16, coordinate width (signed two's complement).
REQ-002 SHALL have parameter LABEL_W, default 8, class label width.
REQ-003 SHALL have parameter K, default 4, number of neighbours kept (1..8).
REQ-004 SHALL have parameter NPTS_W, default 8, training-set index width.
REQ-005 SHALL have ports: clk  in  1  sole clock, rising edge; rst  in  1  synchronous active-high reset.
REQ-006 SHALL have ports: start  in  1  begin classification (pulse); npts  in  NPTS_W  training point count; tx, ty  in  COORD_W each  test point.
REQ-007 SHALL have fetch ports: pt_req  out  1  request; pt_addr  out  NPTS_W  point index; pt_valid  in  1  data valid; pt_x, pt_y  in  COORD_W; pt_label  in  LABEL_W.
REQ-008 SHALL have status ports: busy  out  1; done  out  1  one-cycle pulse; best_label  out  LABEL_W; best_dist  out  2*COORD_W+2  nearest squared distance.
REQ-009 SHALL have readback ports: nb_idx  in  log2(K) (min 1); nb_dist  out  2*COORD_W+2; nb_label  out  LABEL_W (combinational read of sorted list).

Function
REQ-010 SHALL implement FSM IDLE, FETCH, DIST, INSERT, VOTE, DONE.
REQ-011 IDLE: start=1 latches tx, ty, npts, clears list, sets index 0, goes to FETCH (npts!=0) or DONE (npts==0).
REQ-012 FETCH: pt_req=1, pt_addr=index, held until pt_valid=1; point captured on that cycle, go to DIST.
REQ-013 DIST: registers d=(pt_x-tx)^2+(pt_y-ty)^2 at 2*COORD_W+2 bits, no overflow; one cycle.
REQ-014 INSERT: one-cycle parallel compare-shift into K-entry list sorted ascending; new entry placed after all entries with dist <= d (earlier index wins ties); entry K-1 dropped.
REQ-015 After INSERT: index==npts-1 -> VOTE (or DONE when vote disabled), else index+1 -> FETCH.
REQ-016 Empty list entries SHALL hold dist all-ones, label 0, valid 0; invalid entries never outvote.
REQ-017 DONE: done=1 for exactly one cycle, best_label/best_dist updated, return to IDLE.
REQ-018 busy=1 in every state except IDLE; start while busy ignored.
REQ-019 npts==0: done asserted 2 cycles after start, best_dist all-ones, best_label 0.
REQ-020 Per-point latency SHALL be 3 cycles with pt_valid returned same cycle as pt_req.
REQ-021 best_label/best_dist SHALL hold their value until the next DONE.

Reset
REQ-022 rst SHALL force IDLE, busy=0, done=0, pt_req=0, pt_addr=0, best_label=0, best_dist=0, list cleared per REQ-016, at any state including mid-operation.

Configuration
REQ-023 Macro KNN_CTRL_VOTE_EN defined: VOTE state spends K cycles counting per-entry label occurrences among valid entries; best_label = most frequent label, tie -> label of lowest-index (nearest) entry among tied.
REQ-024 Macro undefined: no VOTE state or counters; best_label = label of list entry 0.
REQ-025 best_dist SHALL equal entry 0 dist in both configurations.

Structure
REQ-026 State encoding, distance width constant and empty-entry constant SHALL live in shared package knn_pkg.
REQ-027 Squared-distance arithmetic SHALL be sub-module knn_dist (combinational, signed inputs, unsigned output); knn_ctrl registers its output.

Verification
REQ-028 Reset mid-FETCH at index 3 -> next cycle busy=0, pt_req=0, nb_dist all-ones for all nb_idx.
REQ-029 tx=ty=0, points (3,4,L1),(1,1,L2),(0,2,L3),(5,0,L1),(-1,0,L4), K=4 -> list dist 1,2,4,25 labels L4,L2,L3,L1; best_dist=1.
REQ-030 Equal distances: points (1,0,L5),(0,1,L6) -> entry0 label L5, entry1 L6.
REQ-031 KNN_CTRL_VOTE_EN, K=4, neighbour labels 2,7,7,2 ordered by distance -> best_label=2; labels 3,7,7,1 -> 7; undefined -> label of entry 0.
REQ-032 npts=0 -> done 2 cycles after start, best_label=0, best_dist all-ones; start during busy -> ignored, npts unchanged.
REQ-033 Coordinates -32768 vs 32767 both axes -> best_dist = 2*65535^2 = 0x1_FFFC_0002, no wrap.
